// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch response path.
// Width defaults may be overridden by defining the CFG_* macros before this file.
`ifndef CFG_ADDR_W
`define CFG_ADDR_W 32
`endif
`ifndef CFG_DATA_W
`define CFG_DATA_W 32
`endif
`ifndef CFG_FETCH_DEPTH
`define CFG_FETCH_DEPTH 2
`endif

package fetch_pkg;

    localparam int FETCH_ADDR_W = `CFG_ADDR_W;
    localparam int FETCH_DATA_W = `CFG_DATA_W;
    localparam int FETCH_DEPTH  = `CFG_FETCH_DEPTH;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] inst;
        logic                    misalign;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_rsp_queue.sv
// In-order FIFO of fetched {pc, inst, misalign} entries.
// Flush clears count and pointers at the next edge; storage is not reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;
    logic             w_full;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && !i_flush;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

    ovf_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && w_full && !w_pop));

endmodule

// File: rtl/inst_fetch_rsp.sv
// Fetch response: accepts PCs, reads 1-cycle instruction memory,
// queues {pc, inst} pairs in order for decode; execute jumps flush.
module inst_fetch_rsp
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_ifu_valid,
    output logic              o_ifu_ready,
    input  logic [ADDR_W-1:0] i_ifu_pc,
    input  logic              i_exu_jmp_en,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_idu_valid,
    input  logic              i_idu_ready,
    output logic [ADDR_W-1:0] o_idu_pc,
    output logic [DATA_W-1:0] o_idu_inst,
    output logic              o_idu_misalign
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              r_inflight;
    logic              r_discard;
    logic [ADDR_W-1:0] r_pc;

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_free;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    assign o_idu_valid = !w_empty;
    assign w_pop       = o_idu_valid && i_idu_ready;

    // Slots left after this cycle's pop must exceed the read already in flight.
    assign w_free = (CNT_W+1)'(DEPTH) - {1'b0, w_count}
                  + {{CNT_W{1'b0}}, w_pop};

    assign o_ifu_ready = i_sys_rst_n && !i_exu_jmp_en
                      && (w_free > {{CNT_W{1'b0}}, r_inflight});

    assign w_accept      = i_ifu_valid && o_ifu_ready;
    assign o_mem_rd_en   = w_accept;
    assign o_mem_rd_addr = w_accept ? {i_ifu_pc[ADDR_W-1:2], 2'b00} : '0;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_pc       <= '0;
        end else begin
            r_inflight <= w_accept;
            r_discard  <= i_exu_jmp_en;
            if (w_accept) r_pc <= i_ifu_pc;
        end
    end

    assign w_push = r_inflight && !r_discard && !i_exu_jmp_en;

    always_comb begin
        w_entry          = '0;
        w_entry.pc       = r_pc;
        w_entry.inst     = i_mem_rd_data;
        w_entry.misalign = (r_pc[1:0] != 2'b00);
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (i_sys_clk),
        .i_rst_n (i_sys_rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (i_exu_jmp_en),
        .o_count (w_count),
        .o_head  (w_head),
        .o_empty (w_empty)
    );

    assign o_idu_pc       = o_idu_valid ? w_head.pc       : '0;
    assign o_idu_inst     = o_idu_valid ? w_head.inst     : '0;
    assign o_idu_misalign = o_idu_valid ? w_head.misalign : 1'b0;

endmodule
